// File: rtl/car_anim_pkg.sv
// Shared types and helpers for the lane car animator.
package car_anim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT,
    ST_GAP
  } emit_state_t;

  // Bits needed to hold a request count from 0 to max_pending inclusive.
  function automatic int pending_width(input int max_pending);
    return $clog2(max_pending + 1);
  endfunction

endpackage

// File: rtl/car_emitter.sv
// Car emitter: request queue counter plus IDLE/EMIT/GAP sequencer that
// decides when a new car enters column 0 and how long it stays there.
module car_emitter
  import car_anim_pkg::*;
#(
  parameter int CAR_LEN     = 2,
  parameter int GAP         = 1,
  parameter int MAX_PENDING = 7,
  parameter int PW          = pending_width(MAX_PENDING)
) (
  input  logic          traffic_clk,
  input  logic          reset_n,
  input  logic          add_car,
  input  logic          hold,
  output logic          start,
  output logic          emit_on,
  output logic          decrement_car,
  output logic [PW-1:0] pending
);

  localparam int CNT_MAX = (CAR_LEN > GAP) ? CAR_LEN : GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] LAST_EMIT = CW'(CAR_LEN - 1);
  localparam logic [CW-1:0] LAST_GAP  = CW'(GAP - 1);
  localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PENDING);

  emit_state_t   state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [PW-1:0] pending_nx;
  logic          inc;

  // Next state: hold only gates the IDLE->EMIT decision; emit_on is the
  // value column 0 takes at the coming edge.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    start    = 1'b0;
    emit_on  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!hold && (pending != '0 || add_car)) begin
          start    = 1'b1;
          emit_on  = 1'b1;
          state_nx = ST_EMIT;
          cnt_nx   = '0;
        end
      end
      ST_EMIT: begin
        if (cnt == LAST_EMIT) begin
          state_nx = ST_GAP;
          cnt_nx   = '0;
        end else begin
          emit_on = 1'b1;
          cnt_nx  = cnt + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt == LAST_GAP) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Request counter: a saturated queue still accepts a request when a
  // start frees a slot in the same cycle.
  always_comb begin
    inc        = add_car && ((pending != PEND_MAX) || start);
    pending_nx = pending;
    if (inc && !start) begin
      pending_nx = pending + 1'b1;
    end else if (!inc && start) begin
      pending_nx = pending - 1'b1;
    end
  end

  // Sequencer, counter and request-count registers.
  always_ff @(posedge traffic_clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      pending       <= '0;
      decrement_car <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      pending       <= pending_nx;
      decrement_car <= start;
    end
  end

endmodule

// File: rtl/car_turn_animator.sv
// Lane animator: shifts emitted cars along a horizontal array and routes
// each car at the end either into the vertical turn array or off-screen.
module car_turn_animator
  import car_anim_pkg::*;
#(
  parameter int H_LEN       = 11,
  parameter int V_LEN       = 8,
  parameter int LANES       = 2,
  parameter int CAR_LEN     = 2,
  parameter int GAP         = 1,
  parameter int MAX_PENDING = 7
) (
  input  logic                                   traffic_clk,
  input  logic                                   reset_n,
  input  logic                                   add_car,
  input  logic                                   hold,
  input  logic                                   turn_en,
  output logic [LANES-1:0][H_LEN-1:0]            car_move_array_h,
  output logic [V_LEN-1:0][LANES-1:0]            car_move_array_v,
  output logic                                   decrement_car,
  output logic                                   car_exited,
  output logic [pending_width(MAX_PENDING)-1:0]  pending
);

  localparam int PW = pending_width(MAX_PENDING);

  logic                          start;
  logic                          emit_on;
  logic [H_LEN-1:0][LANES-1:0]   col;
  logic [H_LEN-1:0]              tag;
  logic [V_LEN-1:0][LANES-1:0]   row;
  logic                          s_now, s_next, t_now, t_next;

  car_emitter #(
    .CAR_LEN     (CAR_LEN),
    .GAP         (GAP),
    .MAX_PENDING (MAX_PENDING),
    .PW          (PW)
  ) u_emitter (
    .traffic_clk   (traffic_clk),
    .reset_n       (reset_n),
    .add_car       (add_car),
    .hold          (hold),
    .start         (start),
    .emit_on       (emit_on),
    .decrement_car (decrement_car),
    .pending       (pending)
  );

  // Shift arrays: tag travels with its column; the tag at the last column
  // decides whether the leaving cell turns or goes straight off-screen.
  always_ff @(posedge traffic_clk or negedge reset_n) begin
    if (!reset_n) begin
      col <= '0;
      tag <= '0;
      row <= '0;
    end else begin
      col[0] <= {LANES{emit_on}};
      tag[0] <= start ? turn_en : tag[0];
      for (int k = 1; k < H_LEN; k++) begin
        col[k] <= col[k-1];
        tag[k] <= tag[k-1];
      end
      row[0] <= tag[H_LEN-1] ? col[H_LEN-1] : '0;
      for (int r = 1; r < V_LEN; r++) begin
        row[r] <= row[r-1];
      end
    end
  end

  // Exit points: a straight cell in the last column, a turn cell in the
  // last row. "next" is what will occupy that point after the edge.
  always_comb begin
    s_now  = (|col[H_LEN-1]) & ~tag[H_LEN-1];
    s_next = (|col[H_LEN-2]) & ~tag[H_LEN-2];
    t_now  = |row[V_LEN-1];
    t_next = |row[V_LEN-2];
  end

  // Pulse when the trailing cell of a car leaves either exit point.
  always_ff @(posedge traffic_clk or negedge reset_n) begin
    if (!reset_n) begin
      car_exited <= 1'b0;
    end else begin
      car_exited <= (s_now & ~s_next) | (t_now & ~t_next);
    end
  end

  // Present the horizontal array lane-major for the drawing logic.
  always_comb begin
    car_move_array_h = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int k = 0; k < H_LEN; k++) begin
        car_move_array_h[l][k] = col[k][l];
      end
    end
    car_move_array_v = row;
  end

endmodule
